// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared definitions for the reg_bank register file.
//   reg_op_e  - operation encoding driven on reg_bank.op / reg_cell.op
//   sel_width - width of a register select for a given register count
package reg_bank_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } reg_op_e;

    // Select width is max(1, clog2(n)) so a two-entry bank still has a 1-bit select.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_bank_cell.sv
// reg_cell: one register of the bank with load / increment / decrement.
//   clk   - clock, state updates on rising edge
//   reset - synchronous active-low reset, loads RESET_VAL
//   op    - operation for this cell (HOLD when the cell is not targeted)
//   data  - load value for OP_LOAD
//   q     - current register value
//   wrap  - combinational: the current op would wrap (INC from all-ones / DEC from zero)
module reg_cell
    import reg_bank_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  reg_op_e          op,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d  = q_q;
        wrap = 1'b0;
        case (op)
            OP_LOAD: q_d = data;
            OP_INC: begin
                q_d  = q_q + WIDTH'(1);
                wrap = &q_q;
            end
            OP_DEC: begin
                q_d  = q_q - WIDTH'(1);
                wrap = ~|q_q;
            end
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/reg_bank.sv
// reg_bank: small register file with one op port and two combinational read ports.
//   clk                  - clock, all state updates on rising edge
//   reset                - synchronous active-low reset (overrides any op that cycle)
//   op / op_sel / op_data - operation, target register and LOAD value
//   rd_sel_a / rd_sel_b  - read selects; out-of-range selects read 0
//   rd_data_a / rd_data_b - read data
//   wrap                 - registered pulse, previous INC/DEC wrapped
//   sel_err              - registered pulse, previous non-HOLD op had op_sel >= NUM_REGS
// Build option: define REG_BANK_BYPASS_EN to forward a same-cycle LOAD to matching
// read ports (write-first); otherwise reads return the pre-update value.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      NUM_REGS  = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned     SELW      = sel_width(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  reg_op_e          op,
    input  logic [SELW-1:0]  op_sel,
    input  logic [WIDTH-1:0] op_data,
    input  logic [SELW-1:0]  rd_sel_a,
    input  logic [SELW-1:0]  rd_sel_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             wrap,
    output logic             sel_err
);

    // Every select code gets a slot; slots past NUM_REGS are tied to zero so
    // out-of-range reads need no separate range check.
    localparam int unsigned NumSlots = 2 ** SELW;

    logic [WIDTH-1:0]    q_arr [NumSlots];
    logic [NUM_REGS-1:0] cell_wrap;
    logic                sel_ok;
    logic                wrap_q, wrap_d;
    logic                sel_err_q, sel_err_d;

    assign sel_ok = 32'(op_sel) < NUM_REGS;

    for (genvar i = 0; i < NumSlots; i++) begin : g_slot
        if (i < NUM_REGS) begin : g_cell
            reg_op_e cell_op;

            // Only the addressed, in-range cell sees the op; the rest hold.
            assign cell_op = (sel_ok && (op_sel == SELW'(i))) ? op : OP_HOLD;

            reg_cell #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_cell (
                .clk   (clk),
                .reset (reset),
                .op    (cell_op),
                .data  (op_data),
                .q     (q_arr[i]),
                .wrap  (cell_wrap[i])
            );
        end else begin : g_pad
            assign q_arr[i] = '0;
        end
    end

    always_comb begin
        rd_data_a = q_arr[rd_sel_a];
        rd_data_b = q_arr[rd_sel_b];
`ifdef REG_BANK_BYPASS_EN
        if ((op == OP_LOAD) && sel_ok) begin
            if (rd_sel_a == op_sel) rd_data_a = op_data;
            if (rd_sel_b == op_sel) rd_data_b = op_data;
        end
`endif
    end

    always_comb begin
        wrap_d    = |cell_wrap;
        sel_err_d = (op != OP_HOLD) && !sel_ok;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wrap_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            wrap_q    <= wrap_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign wrap    = wrap_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed scoreboard bench for reg_bank.
// u4: default 4-register bank, RESET_VAL 0. u3: 3-register bank, RESET_VAL 8'h0C,
// used for the out-of-range select case.
module tb_reg_bank;
    import reg_bank_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    reg_op_e     op4, op3;
    logic [1:0]  sel4, ra4, rb4, sel3, ra3, rb3;
    logic [7:0]  data4, data3;
    logic [7:0]  rd_a4, rd_b4, rd_a3, rd_b3;
    logic        wrap4, err4, wrap3, err3;

    reg_bank #(.WIDTH(8), .NUM_REGS(4), .RESET_VAL(8'h00)) u4 (
        .clk(clk), .reset(reset), .op(op4), .op_sel(sel4), .op_data(data4),
        .rd_sel_a(ra4), .rd_sel_b(rb4), .rd_data_a(rd_a4), .rd_data_b(rd_b4),
        .wrap(wrap4), .sel_err(err4)
    );

    reg_bank #(.WIDTH(8), .NUM_REGS(3), .RESET_VAL(8'h0C)) u3 (
        .clk(clk), .reset(reset), .op(op3), .op_sel(sel3), .op_data(data3),
        .rd_sel_a(ra3), .rd_sel_b(rb3), .rd_data_a(rd_a3), .rd_data_b(rd_b3),
        .wrap(wrap3), .sel_err(err3)
    );

    typedef struct {
        string      tag;
        int         sig;
        logic [7:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  tests = 0;
    int  fails = 0;

    function automatic logic [7:0] observe(input int sig);
        case (sig)
            0:       return rd_a4;
            1:       return rd_b4;
            2:       return {7'b0, wrap4};
            3:       return {7'b0, err4};
            4:       return rd_a3;
            5:       return rd_b3;
            6:       return {7'b0, wrap3};
            default: return {7'b0, err3};
        endcase
    endfunction

    task automatic push(input string tag, input int sig, input logic [7:0] exp);
        sb_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check();
        while (sb_q.size() > 0) begin
            sb_t e;
            logic [7:0] obs;
            e   = sb_q.pop_front();
            obs = observe(e.sig);
            tests++;
            assert (obs === e.exp) else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd4(input logic [1:0] r, input logic [7:0] e, input string tag);
        ra4 = r;
        rb4 = r;
        #1;
        push(tag, 0, e);
        push(tag, 1, e);
        check();
    endtask

    task automatic rd3(input logic [1:0] r, input logic [7:0] e, input string tag);
        ra3 = r;
        rb3 = r;
        #1;
        push(tag, 4, e);
        push(tag, 5, e);
        check();
    endtask

    task automatic flags4(input logic w, input logic s, input string tag);
        push({tag, "_wrap"}, 2, {7'b0, w});
        push({tag, "_selerr"}, 3, {7'b0, s});
        check();
    endtask

    initial begin
        reset = 1'b0;
        op4 = OP_HOLD; sel4 = '0; data4 = '0; ra4 = '0; rb4 = '0;
        op3 = OP_HOLD; sel3 = '0; data3 = '0; ra3 = '0; rb3 = '0;
        tick();
        reset = 1'b1;

        // Reset state
        flags4(1'b0, 1'b0, "rst4");
        push("rst3_wrap", 6, 8'h00);
        push("rst3_selerr", 7, 8'h00);
        check();
        for (int r = 0; r < 4; r++) rd4(2'(r), 8'h00, "rst4_reg");
        for (int r = 0; r < 3; r++) rd3(2'(r), 8'h0C, "rst3_reg");
        rd3(2'd3, 8'h00, "rst3_oob_read");

        // LOAD A5 to reg 2, others unchanged
        op4 = OP_LOAD; sel4 = 2'd2; data4 = 8'hA5;
        tick();
        op4 = OP_HOLD;
        flags4(1'b0, 1'b0, "load_flags");
        rd4(2'd2, 8'hA5, "load_a5");
        rd4(2'd0, 8'h00, "load_other0");
        rd4(2'd1, 8'h00, "load_other1");
        rd4(2'd3, 8'h00, "load_other3");
        ra4 = 2'd2; rb4 = 2'd0;
        #1;
        push("split_a", 0, 8'hA5);
        push("split_b", 1, 8'h00);
        check();

        // INC wrap then DEC wrap on reg 1
        op4 = OP_LOAD; sel4 = 2'd1; data4 = 8'hFF;
        tick();
        op4 = OP_INC;
        tick();
        op4 = OP_HOLD;
        flags4(1'b1, 1'b0, "inc_wrap");
        rd4(2'd1, 8'h00, "inc_wrap_val");
        tick();
        flags4(1'b0, 1'b0, "inc_wrap_clear");
        op4 = OP_DEC;
        tick();
        op4 = OP_HOLD;
        flags4(1'b1, 1'b0, "dec_wrap");
        rd4(2'd1, 8'hFF, "dec_wrap_val");
        tick();
        flags4(1'b0, 1'b0, "dec_wrap_clear");

        // Non-wrapping INC / DEC
        op4 = OP_INC; sel4 = 2'd2;
        tick();
        op4 = OP_HOLD;
        flags4(1'b0, 1'b0, "inc_nowrap");
        rd4(2'd2, 8'hA6, "inc_a6");
        op4 = OP_DEC; sel4 = 2'd1;
        tick();
        op4 = OP_HOLD;
        flags4(1'b0, 1'b0, "dec_nowrap");
        rd4(2'd1, 8'hFE, "dec_fe");

        // Back-to-back INC from 0x10
        op4 = OP_LOAD; sel4 = 2'd0; data4 = 8'h10;
        tick();
        op4 = OP_INC;
        tick();
        tick();
        op4 = OP_HOLD;
        rd4(2'd0, 8'h12, "inc_inc");

        // Out-of-range select on the 3-register bank
        op3 = OP_LOAD; sel3 = 2'd2; data3 = 8'h11;
        tick();
        op3 = OP_LOAD; sel3 = 2'd3; data3 = 8'h33;
        tick();
        op3 = OP_HOLD;
        push("oob_selerr", 7, 8'h01);
        push("oob_wrap", 6, 8'h00);
        check();
        rd3(2'd0, 8'h0C, "oob_reg0");
        rd3(2'd1, 8'h0C, "oob_reg1");
        rd3(2'd2, 8'h11, "oob_reg2");
        rd3(2'd3, 8'h00, "oob_read3");
        tick();
        push("oob_selerr_clear", 7, 8'h00);
        check();

        // Same-cycle LOAD vs read on reg 0
        op4 = OP_LOAD; sel4 = 2'd0; data4 = 8'h5A; ra4 = 2'd0; rb4 = 2'd3;
        #1;
`ifdef REG_BANK_BYPASS_EN
        push("bypass_a", 0, 8'h5A);
`else
        push("bypass_a", 0, 8'h12);
`endif
        push("bypass_b_other", 1, 8'h00);
        check();
        tick();
        op4 = OP_HOLD;
        rd4(2'd0, 8'h5A, "load_5a");
        op4 = OP_INC; sel4 = 2'd0; ra4 = 2'd0;
        #1;
        push("inc_no_bypass", 0, 8'h5A);
        check();
        tick();
        op4 = OP_HOLD;
        rd4(2'd0, 8'h5B, "inc_5b");

        // INC on reg 3 in the reset cycle is lost
        op4 = OP_LOAD; sel4 = 2'd3; data4 = 8'hFF;
        tick();
        op4 = OP_INC; reset = 1'b0;
        tick();
        reset = 1'b1; op4 = OP_HOLD;
        flags4(1'b0, 1'b0, "rst_inc");
        rd4(2'd3, 8'h00, "rst_inc_reg3");
        rd4(2'd0, 8'h00, "rst_inc_reg0");
        tick();
        flags4(1'b0, 1'b0, "rst_inc_after");
        rd4(2'd3, 8'h00, "rst_inc_not_deferred");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each register.
REQ-002 SHALL have parameter NUM_REGS, default 4: number of registers, legal range 2..16.
REQ-003 SHALL have parameter RESET_VAL, default '0: value loaded into every register on reset.
REQ-004 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port op, input, 2: operation code (HOLD, LOAD, INC, DEC).
REQ-007 SHALL have port op_sel, input, SELW = max(1, $clog2(NUM_REGS)): target register of op.
REQ-008 SHALL have port op_data, input, WIDTH: load value for LOAD.
REQ-009 SHALL have ports rd_sel_a and rd_sel_b, input, SELW each: read-port selects.
REQ-010 SHALL have ports rd_data_a and rd_data_b, output, WIDTH each: read-port data.
REQ-011 SHALL have port wrap, output, 1: registered one-cycle pulse when INC/DEC wrapped.
REQ-012 SHALL have port sel_err, output, 1: registered one-cycle pulse when a non-HOLD op addressed op_sel >= NUM_REGS.

Function
REQ-013 SHALL execute at most one op per cycle, on the single register op_sel; all other registers hold.
REQ-014 SHALL on LOAD write op_data to the target at the clock edge; the value is visible on read ports the following cycle.
REQ-015 SHALL on INC write target+1 modulo 2^WIDTH; on DEC write target-1 modulo 2^WIDTH.
REQ-016 SHALL pulse wrap for exactly the cycle after an INC from all-ones or a DEC from zero; otherwise wrap = 0.
REQ-017 SHALL on HOLD change no register and drive wrap = 0 and sel_err = 0 the next cycle.
REQ-018 SHALL ignore any non-HOLD op with op_sel >= NUM_REGS (no register changes) and pulse sel_err the following cycle.
REQ-019 SHALL drive rd_data_a/b combinationally from the registers addressed by rd_sel_a/b; out-of-range select reads 0.
REQ-020 SHALL allow both read ports to address the same register, returning identical data.
REQ-021 SHALL give back-to-back ops on the same register cumulative effect (INC, INC from 0x10 yields 0x12).

Reset
REQ-022 SHALL, when reset = 0 at a rising clk edge, set every register to RESET_VAL and wrap = 0, sel_err = 0, overriding any op in that cycle.
REQ-023 SHALL apply reset mid-operation identically; an op presented in the reset cycle is lost, not deferred.
REQ-024 SHALL not change outputs asynchronously on reset; rd_data reflects RESET_VAL from the cycle after the reset edge.

Configuration
REQ-025 SHALL, with macro REG_BANK_BYPASS_EN defined, return op_data on any read port whose select equals op_sel during a LOAD in the same cycle (write-first bypass).
REQ-026 SHALL, without REG_BANK_BYPASS_EN, return the pre-update register value in that case (read-before-write); INC/DEC are never bypassed in either build.

Structure
REQ-027 SHALL take the op encoding from a shared package reg_bank_pkg: typedef enum logic [1:0] {OP_HOLD=0, OP_LOAD=1, OP_INC=2, OP_DEC=3} reg_op_e.
REQ-028 SHALL implement each register as sub-module reg_cell (WIDTH, RESET_VAL; ports clk, reset, op, data, q, wrap), instantiated NUM_REGS times via generate.
REQ-029 SHALL combine the per-cell wrap outputs and the selection decode into the registered wrap/sel_err outputs at top level.

Verification
REQ-030 SHALL cover: reset = 0 for one edge with RESET_VAL = 8'h00 -> all registers read 8'h00, wrap = 0, sel_err = 0.
REQ-031 SHALL cover: LOAD 8'hA5 to reg 2, next cycle read A and B at reg 2 -> both 8'hA5, other registers unchanged.
REQ-032 SHALL cover: LOAD 8'hFF to reg 1, then INC reg 1 -> reg 1 = 8'h00, wrap = 1 for one cycle; then DEC reg 1 -> 8'hFF, wrap = 1 again.
REQ-033 SHALL cover: NUM_REGS = 3, LOAD 8'h33 with op_sel = 3 -> no register changes, sel_err = 1 for one cycle.
REQ-034 SHALL cover: LOAD 8'h5A to reg 0 while rd_sel_a = 0 -> rd_data_a = 8'h5A same cycle with REG_BANK_BYPASS_EN, old value without.
REQ-035 SHALL cover: INC reg 3 asserted in the same cycle as reset = 0 -> reg 3 = RESET_VAL afterwards, wrap = 0.
